pi_bus_master: RTL

//  Initiator end of the Pi bus-request handshake (pi_pending/pi_done). Decodes a byte-stream

---
 rtl/pi_bus_pkg.sv | 28 ++
 rtl/pi_done_sync.sv | 31 +++
 rtl/pi_bus_master.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pi_bus_pkg.sv
// Shared definitions for the Pi bus request handshake.
// Both the initiator (pi_bus_master) and the bus-side responder import this
// package, so the state names, opcode values and timeout byte stay in step.
package pi_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    DATA,
    REQ,
    RELEASE,
    RESP
  } state_t;

  localparam int          ADDR_W        = 17;
  localparam logic [1:0]  OP_READ       = 2'b00;
  localparam logic [1:0]  OP_WRITE      = 2'b01;
  localparam logic [1:0]  OP_READ_NEXT  = 2'b10;
  localparam logic [1:0]  OP_WRITE_NEXT = 2'b11;
  localparam logic [7:0]  TIMEOUT_BYTE  = 8'hFF;

  // Sequential-access address step; wraps 1_FFFF -> 0_0000.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/pi_done_sync.sv
// Two-flop synchroniser for the arbiter's pi_done completion signal.
// Ports:
//   clk16  - 16 MHz master clock
//   res_b  - synchronous active-low reset, clears both flops
//   d      - asynchronous input
//   q      - synchronised output (two clk16 cycles of latency)
module pi_done_sync (
  input  logic clk16,
  input  logic res_b,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk16) begin
    if (!res_b) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      // stage p0: first capture, may go metastable
      sync_p0 <= d;
      // stage p1: settled copy used by the FSM
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/pi_bus_master.sv
// Initiator end of the Pi bus-request handshake.
// Decodes a byte-stream command channel into 17-bit bus reads/writes, runs a
// 4-phase pi_pending/pi_done handshake against the bus timing arbiter and
// returns read bytes (or TIMEOUT_BYTE after an aborted read) on a response stream.
// Ports:
//   clk16, res_b            - clock, synchronous active-low reset
//   rx_valid/rx_data/rx_ready - command byte stream in
//   tx_valid/tx_data/tx_ready - response byte stream out
//   pi_rw_b, pi_addr, pi_data_out - request presented to the arbiter
//   pi_data_in, pi_done     - arbiter read data and completion
//   pi_pending              - request outstanding
//   busy                    - FSM not idle
//   err                     - sticky timeout flag, cleared by the next opcode byte
module pi_bus_master #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk16,
  input  logic        res_b,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        pi_rw_b,
  output logic [16:0] pi_addr,
  output logic [7:0]  pi_data_out,
  input  logic [7:0]  pi_data_in,
  output logic        pi_pending,
  input  logic        pi_done,
  output logic        busy,
  output logic        err
);

  import pi_bus_pkg::*;

  state_t           state;
  state_t           state_nxt;
  logic             done_s;
  logic             seen_low;
  logic [CNT_W-1:0] cnt;
  logic             tmo;
  logic             done_ok;

  pi_done_sync u_done_sync (
    .clk16 (clk16),
    .res_b (res_b),
    .d     (pi_done),
    .q     (done_s)
  );

  assign tmo     = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  // A done level that was already high on entry to REQ is stale; only a
  // low-then-high sequence inside REQ counts as completion.
  assign done_ok = done_s && seen_low;

  always_ff @(posedge clk16) begin
    if (!res_b) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          case (rx_data[7:6])
            OP_READ, OP_WRITE: state_nxt = ADDR_HI;
            OP_READ_NEXT:      state_nxt = REQ;
            default:           state_nxt = DATA;
          endcase
        end
      end
      ADDR_HI: if (rx_valid) state_nxt = ADDR_LO;
      ADDR_LO: if (rx_valid) state_nxt = pi_rw_b ? REQ : DATA;
      DATA:    if (rx_valid) state_nxt = REQ;
      REQ:     if (done_ok || tmo) state_nxt = RELEASE;
      RELEASE: begin
        if (!done_s)  state_nxt = pi_rw_b ? RESP : IDLE;
        else if (tmo) state_nxt = IDLE;
      end
      RESP:    if (tx_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rx_ready   = 1'b0;
    busy       = (state != IDLE);
    pi_pending = (state == REQ);
    tx_valid   = (state == RESP);
    // Gated by res_b so the stream is closed while reset is held.
    if (res_b && (state == IDLE || state == ADDR_HI || state == ADDR_LO || state == DATA))
      rx_ready = 1'b1;
  end

  always_ff @(posedge clk16) begin
    if (!res_b) begin
      cnt         <= '0;
      seen_low    <= 1'b0;
      err         <= 1'b0;
      pi_rw_b     <= 1'b1;
      pi_addr     <= '0;
      pi_data_out <= '0;
      tx_data     <= '0;
    end else begin
      // Timeout count restarts on every state change, so REQ and RELEASE
      // each get a fresh budget.
      if (state_nxt != state || !(state == REQ || state == RELEASE))
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);

      if (state != REQ && state_nxt == REQ)
        seen_low <= 1'b0;
      else if (state == REQ && !done_s)
        seen_low <= 1'b1;

      case (state)
        IDLE: begin
          if (rx_valid) begin
            err     <= 1'b0;
            pi_rw_b <= ~rx_data[6];
            if (rx_data[7]) pi_addr     <= addr_inc(pi_addr);
            else            pi_addr[16] <= rx_data[0];
          end
        end
        ADDR_HI: if (rx_valid) pi_addr[15:8] <= rx_data;
        ADDR_LO: if (rx_valid) pi_addr[7:0]  <= rx_data;
        DATA:    if (rx_valid) pi_data_out   <= rx_data;
        REQ: begin
          if (done_ok) begin
            if (pi_rw_b) tx_data <= pi_data_in;
          end else if (tmo) begin
            err <= 1'b1;
            if (pi_rw_b) tx_data <= TIMEOUT_BYTE;
          end
        end
        RELEASE: if (done_s && tmo) err <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
